serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Bit-serial add sequencer built around one instance of the team's 1-bit FullAdder cell (inputs A, B, Cin; outputs Sum, Cout).
- Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Start/Busy/Done handshake; the result is held registered until the next accepted Start.
- Trades WIDTH cycles of latency for a single adder cell in the lab datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 1..32.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on accepted Start.
- B  input  WIDTH  operand B; captured on accepted Start.
- Cin  input  1  carry-in; captured on accepted Start.
- Busy  output  1  high while in RUN.
- Done  output  1  one-cycle pulse when the result is valid.
- Sum  output  WIDTH  registered sum.
- Cout  output  1  registered carry-out.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. RST high at a CLK edge forces state=IDLE, Busy=0, Done=0, Sum=0, Cout=0, counter=0, shift and carry registers=0. RST takes priority over all other inputs.
- States:
  - IDLE: Start=1 moves to RUN. On that edge: shiftA<=A, shiftB<=B, carry<=Cin, acc<=0, cnt<=0.
  - RUN: each edge, the FullAdder sees shiftA[0], shiftB[0], carry. Its Sum bit shifts into acc at the MSB (acc<=ASum,acc[WIDTH-1:1]). carry<=its Cout. shiftA and shiftB shift right by 1. cnt<=cnt+1.
  - RUN exit: on the edge where cnt==WIDTH-1, move to DONE. On that same edge, Sum<=final acc including the last bit, and Cout<=the FullAdder's Cout.
  - DONE: Done=1 for exactly one cycle, then unconditionally IDLE.
- Latency: Start sampled at edge 0 gives Busy=1 for cycles 1..WIDTH and Done=1 in cycle WIDTH+1. Back-to-back throughput is one op per WIDTH+2 cycles.
- Start is ignored in RUN and DONE. No queuing; a request is only accepted in IDLE.
- A, B and Cin may change freely after an accepted Start.
- Sum and Cout change only on the completing edge. They hold previous values during RUN and stay stable indefinitely in IDLE.
- Counter width is $clog2(WIDTH)+1 bits and never wraps within an operation.
- WIDTH=1: RUN lasts one cycle, then DONE.
- Reset mid-RUN: the operation is aborted; no Done pulse; outputs are zeroed.
- Arithmetic: {Cout,Sum} = A + B + Cin, truncated to WIDTH+1 bits. No two's-complement interpretation, except under the optional feature.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output Ovf (1 bit).
  - Reset value 0.
  - Updated on the completing edge with the signed overflow of A+B+Cin: carry into the MSB XOR carry out of the MSB.
  - The carry into the MSB is the carry register value during the last RUN cycle.
- Undefined: no Ovf port and no extra logic.

Decomposition:
- Shared package serial_add_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default width constant SERIAL_ADD_W=8.
- Sub-module: one FullAdder instance, the only arithmetic element.
- The controller (FSM, counter, shift registers, result register) stays in serial_add_ctrl; no further split.

Test Plan:
- Basic add (WIDTH=8): A=0x5A, B=0x3C, Cin=0, Start at edge 0 -> Busy high cycles 1..8; Done in cycle 9; Sum=0x96, Cout=0.
- Carry ripple: A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Cout=1. Then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Cout=1.
- Start while busy: Start held high continuously with A=0x01, B=0x02 -> exactly one result (Sum=0x03) per 10-cycle period. Operand changes during RUN do not affect the result.
- Reset mid-op: A=0xAA, B=0x55, RST=1 at cycle 4 -> next cycle Busy=0, Done never pulses, Sum=0x00, Cout=0. A new Start then completes normally.
- Hold/stability: after a result of 0x96, idle 20 cycles -> Sum stays 0x96 and Done stays 0. During the next op, Sum stays 0x96 until the completing edge.
- SERIAL_ADD_OVF_EN: A=0x7F, B=0x01 -> Sum=0x80, Ovf=1. A=0x80, B=0x80 -> Sum=0x00, Cout=1, Ovf=1. A=0x10, B=0x20 -> Ovf=0.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_add_pkg;

  localparam int SERIAL_ADD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder cell; the only arithmetic element in the serial adder.
module serial_add_ctrl_fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: {Cout,Sum} = A + B + Cin, one bit per clock, LSB first.
// Optional signed-overflow output Ovf is enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sha_q, sha_d;
  logic [WIDTH-1:0] shb_q, shb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_sum, fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  serial_add_ctrl_fa u_fa (
    .A    (sha_q[0]),
    .B    (shb_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_RUN;
          sha_d   = A;
          shb_d   = B;
          carry_d = Cin;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sha_d            = sha_q >> 1;
        shb_d            = shb_q >> 1;
        carry_d          = fa_cout;
        acc_d            = acc_q >> 1;
        acc_d[WIDTH-1]   = fa_sum;
        cnt_d            = cnt_q + CW'(1);
        // Result registers load the accumulator including this cycle's bit.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          sum_d   = acc_d;
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign Busy = (state_q == ST_RUN);
  assign Done = (state_q == ST_DONE);
  assign Sum  = sum_q;
  assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed and random ops vs an arithmetic reference.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         Ovf;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] held_sum;
  logic         held_cout;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .Start (Start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .Busy  (Busy),
    .Done  (Done),
    .Sum   (Sum),
    .Cout  (Cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unsigned reference: full-precision integer sum, keep W+1 bits.
  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint s;
    s = longint'(a) + longint'(b) + longint'(c);
    return s[W:0];
  endfunction

  // Signed reference: overflow when the true two's-complement sum leaves the W-bit range.
  function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    longint sa, sb, s;
    sa = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
    sb = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
    s  = sa + sb + longint'(c);
    return (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
  endfunction

  // One operation; stray Start pulses and operand changes are injected during RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] e;
    e = ref_sum(a, b, c);
    @(negedge CLK);
    chk("busy_idle", Busy, 1'b0);
    chk("done_idle", Done, 1'b0);
    Start = 1'b1;
    A = a;
    B = b;
    Cin = c;
    @(negedge CLK);
    for (int i = 1; i <= W; i++) begin
      chk("busy_run", Busy, 1'b1);
      chk("done_run", Done, 1'b0);
      chk("sum_hold_run", Sum, held_sum);
      chk("cout_hold_run", Cout, held_cout);
      Start = 1'($urandom_range(0, 1));
      A = W'($urandom);
      B = W'($urandom);
      Cin = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    Start = 1'b0;
    chk("busy_done", Busy, 1'b0);
    chk("done_pulse", Done, 1'b1);
    chk("sum", Sum, e[W-1:0]);
    chk("cout", Cout, e[W]);
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", Ovf, ref_ovf(a, b, c));
`endif
    held_sum = e[W-1:0];
    held_cout = e[W];
  endtask

  initial begin
    RST = 1'b1;
    Start = 1'b0;
    A = '0;
    B = '0;
    Cin = 1'b0;
    held_sum = '0;
    held_cout = 1'b0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_sum", Sum, 8'h00);
    chk("rst_cout", Cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    chk("rst_ovf", Ovf, 1'b0);
`endif
    RST = 1'b0;

    do_op(8'h5A, 8'h3C, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1);
    do_op(8'h7F, 8'h01, 1'b0);
    do_op(8'h80, 8'h80, 1'b0);
    do_op(8'h10, 8'h20, 1'b0);

    // Result must stay put while idle and through the next op until its completing edge.
    do_op(8'h5A, 8'h3C, 1'b0);
    repeat (20) begin
      @(negedge CLK);
      chk("sum_hold_idle", Sum, 8'h96);
      chk("done_quiet_idle", Done, 1'b0);
    end
    do_op(8'h11, 8'h22, 1'b1);

    // Start held high: exactly one Done per WIDTH+2 cycles.
    @(negedge CLK);
    Start = 1'b1;
    A = 8'h01;
    B = 8'h02;
    Cin = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      chk("held_start_done", Done, ((c % 10) == 9) ? 1'b1 : 1'b0);
      if ((c % 10) == 9) begin
        chk("held_start_sum", Sum, 8'h03);
      end
    end
    Start = 1'b0;
    held_sum = 8'h03;
    held_cout = 1'b0;

    // Abort mid-run with reset.
    @(negedge CLK);
    Start = 1'b1;
    A = 8'hAA;
    B = 8'h55;
    @(negedge CLK);
    Start = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("abort_busy", Busy, 1'b0);
    chk("abort_done", Done, 1'b0);
    chk("abort_sum", Sum, 8'h00);
    chk("abort_cout", Cout, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    chk("abort_ovf", Ovf, 1'b0);
`endif
    repeat (12) begin
      @(negedge CLK);
      chk("abort_no_done", Done, 1'b0);
      chk("abort_no_busy", Busy, 1'b0);
    end
    held_sum = 8'h00;
    held_cout = 1'b0;
    do_op(8'hAA, 8'h55, 1'b0);

    for (int n = 0; n < 20; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
